// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: buffers retired instructions from wb_unit as ordered commit
// records for a downstream trace consumer (trace port, co-sim checker, ISA monitor).
//
// Optional feature macro: CTRACE_PCCHK_EN. When defined, each record carries a
// PC-discontinuity bit; when undefined, tr_disc_o is tied to 0 and no PC history
// or disc storage exists.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wb_*_i               retiring instruction (wb_valid_i = push request)
//   tr_valid_o/ready_i   head record handshake (pop when both high)
//   tr_*_o               head record fields (first-word fall-through)
//   level_o              occupancy, ovf_o sticky overflow, drop_cnt_o saturating drops
module commit_trace_fifo #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ORDER_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid_i,
  input  logic [XLEN-1:0]            wb_pc_i,
  input  logic [31:0]                wb_insn_i,
  input  logic [4:0]                 wb_rd_i,
  input  logic                       wb_we_i,
  input  logic [XLEN-1:0]            wb_wdata_i,
  output logic                       tr_valid_o,
  input  logic                       tr_ready_i,
  output logic [ORDER_W-1:0]         tr_order_o,
  output logic [XLEN-1:0]            tr_pc_o,
  output logic [31:0]                tr_insn_o,
  output logic [4:0]                 tr_rd_o,
  output logic                       tr_we_o,
  output logic [XLEN-1:0]            tr_wdata_o,
  output logic                       tr_disc_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_q, drop_d;

  logic [ORDER_W-1:0] order_mem [DEPTH];
  logic [XLEN-1:0]    pc_mem    [DEPTH];
  logic [31:0]        insn_mem  [DEPTH];
  logic [4:0]         rd_mem    [DEPTH];
  logic               we_mem    [DEPTH];
  logic [XLEN-1:0]    wdata_mem [DEPTH];

  logic empty, full, pop, push, drop, keep_wb;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && tr_ready_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push    = wb_valid_i && (!full || pop);
  assign drop    = wb_valid_i && full && !pop;
  assign keep_wb = wb_we_i && (wb_rd_i != 5'd0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    order_d = order_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    // Dropped requests still consume an order number so the consumer sees a gap.
    if (wb_valid_i) order_d = order_q + ORDER_W'(1);
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      order_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      order_mem[wptr_q[AW-1:0]] <= order_q;
      pc_mem[wptr_q[AW-1:0]]    <= wb_pc_i;
      insn_mem[wptr_q[AW-1:0]]  <= wb_insn_i;
      rd_mem[wptr_q[AW-1:0]]    <= keep_wb ? wb_rd_i : 5'd0;
      we_mem[wptr_q[AW-1:0]]    <= keep_wb;
      wdata_mem[wptr_q[AW-1:0]] <= keep_wb ? wb_wdata_i : '0;
    end
  end

`ifdef CTRACE_PCCHK_EN
  logic [XLEN-1:0] prev_pc_q;
  logic            prev_vld_q;
  logic            disc_mem [DEPTH];
  logic            disc_in;

  assign disc_in = prev_vld_q && (wb_pc_i != prev_pc_q + XLEN'(4));

  // History follows every request, dropped or not, so disc reflects program flow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
    end else if (wb_valid_i) begin
      prev_pc_q  <= wb_pc_i;
      prev_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) disc_mem[wptr_q[AW-1:0]] <= disc_in;
  end

  assign tr_disc_o = disc_mem[rptr_q[AW-1:0]];
`else
  assign tr_disc_o = 1'b0;
`endif

  assign tr_valid_o = !empty;
  assign tr_order_o = order_mem[rptr_q[AW-1:0]];
  assign tr_pc_o    = pc_mem[rptr_q[AW-1:0]];
  assign tr_insn_o  = insn_mem[rptr_q[AW-1:0]];
  assign tr_rd_o    = rd_mem[rptr_q[AW-1:0]];
  assign tr_we_o    = we_mem[rptr_q[AW-1:0]];
  assign tr_wdata_o = wdata_mem[rptr_q[AW-1:0]];
  assign level_o    = wptr_q - rptr_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed self-checking bench for commit_trace_fifo (default parameters).
module tb_commit_trace_fifo;

  logic        clk;
  logic        rst_n;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic [31:0] wb_insn_i;
  logic [4:0]  wb_rd_i;
  logic        wb_we_i;
  logic [31:0] wb_wdata_i;
  logic        tr_valid_o;
  logic        tr_ready_i;
  logic [15:0] tr_order_o;
  logic [31:0] tr_pc_o;
  logic [31:0] tr_insn_o;
  logic [4:0]  tr_rd_o;
  logic        tr_we_o;
  logic [31:0] tr_wdata_o;
  logic        tr_disc_o;
  logic [3:0]  level_o;
  logic        ovf_o;
  logic [15:0] drop_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  commit_trace_fifo #(
    .XLEN   (32),
    .DEPTH  (8),
    .ORDER_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid_i(wb_valid_i),
    .wb_pc_i   (wb_pc_i),
    .wb_insn_i (wb_insn_i),
    .wb_rd_i   (wb_rd_i),
    .wb_we_i   (wb_we_i),
    .wb_wdata_i(wb_wdata_i),
    .tr_valid_o(tr_valid_o),
    .tr_ready_i(tr_ready_i),
    .tr_order_o(tr_order_o),
    .tr_pc_o   (tr_pc_o),
    .tr_insn_o (tr_insn_o),
    .tr_rd_o   (tr_rd_o),
    .tr_we_o   (tr_we_o),
    .tr_wdata_o(tr_wdata_o),
    .tr_disc_o (tr_disc_o),
    .level_o   (level_o),
    .ovf_o     (ovf_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                       input logic we, input logic [31:0] wdata);
    wb_valid_i = 1'b1;
    wb_pc_i    = pc;
    wb_insn_i  = insn;
    wb_rd_i    = rd;
    wb_we_i    = we;
    wb_wdata_i = wdata;
  endtask

  task automatic push1(input logic [31:0] pc);
    drive(pc, 32'h0000_0013, 5'd2, 1'b1, pc);
    cyc();
    wb_valid_i = 1'b0;
  endtask

  initial begin
    int disc_exp [4];
`ifdef CTRACE_PCCHK_EN
    disc_exp = '{0, 0, 1, 0};
`else
    disc_exp = '{0, 0, 0, 0};
`endif
    rst_n = 1'b0;
    wb_valid_i = 1'b0; wb_pc_i = '0; wb_insn_i = '0; wb_rd_i = '0; wb_we_i = 1'b0;
    wb_wdata_i = '0; tr_ready_i = 1'b0;
    #12;
    chk("rst_valid", tr_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_disc", tr_disc_o, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single record, also no combinational wb -> tr path.
    drive(32'h200, 32'h00A0_0093, 5'd1, 1'b1, 32'd10);
    #1;
    chk("no_comb_path", tr_valid_o, 0);
    cyc();
    wb_valid_i = 1'b0;
    chk("single_valid", tr_valid_o, 1);
    chk("single_order", tr_order_o, 0);
    chk("single_pc", tr_pc_o, 32'h200);
    chk("single_insn", tr_insn_o, 32'h00A0_0093);
    chk("single_rd", tr_rd_o, 1);
    chk("single_we", tr_we_o, 1);
    chk("single_wdata", tr_wdata_o, 10);
    chk("single_level", level_o, 1);
    chk("single_disc", tr_disc_o, 0);
    tr_ready_i = 1'b1;
    cyc();
    tr_ready_i = 1'b0;
    chk("single_pop_level", level_o, 0);
    chk("single_pop_valid", tr_valid_o, 0);

    // Normalisation: rd=0 with we=1, then we=0 with rd!=0.
    drive(32'h204, 32'h0550_0013, 5'd0, 1'b1, 32'h55);
    cyc();
    drive(32'h208, 32'h0770_0193, 5'd3, 1'b0, 32'h77);
    cyc();
    wb_valid_i = 1'b0;
    chk("norm0_order", tr_order_o, 1);
    chk("norm0_rd", tr_rd_o, 0);
    chk("norm0_we", tr_we_o, 0);
    chk("norm0_wdata", tr_wdata_o, 0);
    chk("norm_level", level_o, 2);
    tr_ready_i = 1'b1;
    cyc();
    chk("norm1_order", tr_order_o, 2);
    chk("norm1_pc", tr_pc_o, 32'h208);
    chk("norm1_rd", tr_rd_o, 0);
    chk("norm1_we", tr_we_o, 0);
    chk("norm1_wdata", tr_wdata_o, 0);
    cyc();
    tr_ready_i = 1'b0;
    chk("norm_drained", level_o, 0);

    // Fresh start for overflow so orders begin at 0.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();

    // Overflow: 10 pushes into 8 entries with ready low.
    for (int i = 0; i < 10; i++) begin
      drive(32'h400 + 32'(4 * i), 32'h0000_0013, 5'd4, 1'b1, 32'(i));
      cyc();
    end
    wb_valid_i = 1'b0;
    chk("ovf_level", level_o, 8);
    chk("ovf_flag", ovf_o, 1);
    chk("ovf_drop", drop_cnt_o, 2);
    cyc();
    chk("ovf_head_stable", tr_order_o, 0);
    tr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_order%0d", i), tr_order_o, 64'(i));
      chk($sformatf("drain_wdata%0d", i), tr_wdata_o, 64'(i));
      cyc();
    end
    tr_ready_i = 1'b0;
    chk("drain_empty", tr_valid_o, 0);
    chk("ovf_sticky", ovf_o, 1);
    push1(32'h428);
    chk("gap_order", tr_order_o, 10);
    chk("gap_disc", tr_disc_o, 0);
    tr_ready_i = 1'b1;
    cyc();
    tr_ready_i = 1'b0;

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push1(32'h42C + 32'(4 * i));
    chk("full_level", level_o, 8);
    chk("full_head", tr_order_o, 11);
    drive(32'h44C, 32'h0000_0013, 5'd5, 1'b1, 32'h99);
    tr_ready_i = 1'b1;
    cyc();
    wb_valid_i = 1'b0;
    chk("pp_level", level_o, 8);
    chk("pp_drop", drop_cnt_o, 2);
    chk("pp_head", tr_order_o, 12);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_order%0d", i), tr_order_o, 64'(12 + i));
      cyc();
    end
    tr_ready_i = 1'b0;
    chk("pp_empty", level_o, 0);

    // Async reset with 5 records queued.
    for (int i = 0; i < 5; i++) push1(32'h500 + 32'(4 * i));
    chk("pre_rst_level", level_o, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", tr_valid_o, 0);
    chk("arst_level", level_o, 0);
    chk("arst_ovf", ovf_o, 0);
    chk("arst_drop", drop_cnt_o, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // PC discontinuity sequence; orders restart at 0.
    push1(32'h200);
    push1(32'h204);
    push1(32'h300);
    push1(32'h304);
    tr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_order%0d", i), tr_order_o, 64'(i));
      chk($sformatf("disc%0d", i), tr_disc_o, 64'(disc_exp[i]));
      cyc();
    end
    tr_ready_i = 1'b0;
    chk("final_empty", tr_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
